// File: rtl/tap_delay_line_reader.sv
// Circular tap-delay line for the ANC adaptive filter.
// Each accepted sample is written into a circular history of TAPS entries.
// The whole history is then streamed newest-first over a valid/ready port.
// Taps that have not been written since reset read as zero.
module tap_delay_line_reader #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_sample,
    output logic                     in_ready,
    output logic                     tap_valid,
    input  logic                     tap_ready,
    output logic signed [DATA_W-1:0] tap_data,
    output logic [ADDR_W-1:0]        tap_index,
    output logic                     tap_last,
    output logic                     busy,
    output logic                     overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W + 1)'(TAPS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAPS - 1);

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]          base_q, base_d;
    logic [ADDR_W-1:0]          idx_q, idx_d;
    logic [ADDR_W:0]            fill_q, fill_d;
    logic                       overrun_q, overrun_d;
    logic                       tap_valid_q, tap_valid_d;
    logic                       tap_last_q, tap_last_d;
    logic signed [DATA_W-1:0]   tap_data_q, tap_data_d;

    logic signed [DATA_W-1:0]   mem [TAPS];
    logic                       accept;
    logic [ADDR_W-1:0]          rd_idx;
    logic [ADDR_W-1:0]          rd_addr;

    // Count of valid history entries, saturating once the line is full.
    function automatic logic [ADDR_W:0] sat_fill(input logic [ADDR_W:0] f);
        return (f >= FILL_MAX) ? FILL_MAX : f + 1'b1;
    endfunction

    // Zero taps older than anything written since reset; otherwise pass the
    // stored sample through bit-exact.
    function automatic logic signed [DATA_W-1:0] mask_tap(
        input logic [ADDR_W-1:0]        i,
        input logic [ADDR_W:0]          f,
        input logic signed [DATA_W-1:0] s
    );
        return ({1'b0, i} >= f) ? '0 : s;
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid && in_ready;
    assign tap_valid = tap_valid_q;
    assign tap_data  = tap_data_q;
    assign tap_index = idx_q;
    assign tap_last  = tap_last_q;
    assign overrun   = overrun_q;

    // Next-state logic: handshake, pointer bookkeeping and tap presentation.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        base_d      = base_q;
        idx_d       = idx_q;
        fill_d      = fill_q;
        overrun_d   = overrun_q;
        tap_valid_d = tap_valid_q;
        tap_last_d  = tap_last_q;
        tap_data_d  = tap_data_q;

        // Tap fetched for the next presented beat: tap 0 in LOAD, idx+1 in STREAM.
        rd_idx  = (state_q == STREAM) ? idx_q + 1'b1 : '0;
        rd_addr = base_q - rd_idx;

        // A sample offered while not ready is dropped and flagged for good.
        if (in_valid && !in_ready) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    base_d   = wr_ptr_q;
                    fill_d   = sat_fill(fill_q);
                    idx_d    = '0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                tap_valid_d = 1'b1;
                tap_data_d  = mask_tap(rd_idx, fill_q, mem[rd_addr]);
                tap_last_d  = 1'b0;
                state_d     = STREAM;
            end
            STREAM: begin
                if (tap_ready) begin
                    if (idx_q == LAST_IDX) begin
                        tap_valid_d = 1'b0;
                        tap_last_d  = 1'b0;
                        idx_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        idx_d      = rd_idx;
                        tap_data_d = mask_tap(rd_idx, fill_q, mem[rd_addr]);
                        tap_last_d = (rd_idx == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            base_q      <= '0;
            idx_q       <= '0;
            fill_q      <= '0;
            overrun_q   <= 1'b0;
            tap_valid_q <= 1'b0;
            tap_last_q  <= 1'b0;
            tap_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            fill_q      <= fill_d;
            overrun_q   <= overrun_d;
            tap_valid_q <= tap_valid_d;
            tap_last_q  <= tap_last_d;
            tap_data_q  <= tap_data_d;
        end
    end

    // History storage; never cleared, stale entries are hidden by fill.
    always_ff @(posedge clk) begin
        if (rst && accept) begin
            mem[wr_ptr_q] <= in_sample;
        end
    end

endmodule

// File: tb/tb_tap_delay_line_reader.sv
// Directed testbench for tap_delay_line_reader.
module tb_tap_delay_line_reader;

    localparam int DATA_W = 16;
    localparam int TAPS   = 32;
    localparam int ADDR_W = 5;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     in_valid = 1'b0;
    logic signed [DATA_W-1:0] in_sample = '0;
    logic                     in_ready;
    logic                     tap_valid;
    logic                     tap_ready = 1'b0;
    logic signed [DATA_W-1:0] tap_data;
    logic [ADDR_W-1:0]        tap_index;
    logic                     tap_last;
    logic                     busy;
    logic                     overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Newest-first history of accepted samples since the last reset.
    logic signed [DATA_W-1:0] hist [$];

    logic signed [DATA_W-1:0] got_data [TAPS];
    logic [ADDR_W-1:0]        got_idx  [TAPS];
    logic                     got_last [TAPS];
    int                       got_n;
    int                       got_cyc;
    int                       stall_bad;

    tap_delay_line_reader #(
        .DATA_W(DATA_W),
        .TAPS  (TAPS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_sample(in_sample),
        .in_ready (in_ready),
        .tap_valid(tap_valid),
        .tap_ready(tap_ready),
        .tap_data (tap_data),
        .tap_index(tap_index),
        .tap_last (tap_last),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        tap_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        hist.delete();
    endtask

    function automatic logic signed [DATA_W-1:0] exp_tap(input int i);
        if (i < hist.size()) return hist[i];
        return '0;
    endfunction

    // Offer one sample once in_ready is seen; returns at the LOAD cycle.
    task automatic send(input logic signed [DATA_W-1:0] s);
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_wait: in_ready=%0b required 1", in_ready);
        end
        in_valid  = 1'b1;
        in_sample = s;
        tick();
        in_valid = 1'b0;
        hist.push_front(s);
        if (hist.size() > TAPS) void'(hist.pop_back());
    endtask

    // Collect one frame of beats; tracks whether stalled beats stay stable.
    task automatic read_frame(input bit rnd);
        logic                     stalled;
        logic signed [DATA_W-1:0] hd;
        logic [ADDR_W-1:0]        hi;
        logic                     hl;
        stalled   = 1'b0;
        hd        = '0;
        hi        = '0;
        hl        = 1'b0;
        got_n     = 0;
        got_cyc   = 0;
        stall_bad = 0;
        for (int c = 0; c < 3000 && got_n < TAPS; c++) begin
            if (stalled && (tap_valid !== 1'b1 || tap_data !== hd ||
                            tap_index !== hi || tap_last !== hl))
                stall_bad++;
            tap_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled   = tap_valid && !tap_ready;
            hd        = tap_data;
            hi        = tap_index;
            hl        = tap_last;
            if (tap_valid && tap_ready) begin
                got_data[got_n] = tap_data;
                got_idx[got_n]  = tap_index;
                got_last[got_n] = tap_last;
                got_n++;
            end
            tick();
            got_cyc++;
        end
        tap_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        in_valid = 1'b1;
        in_sample = 16'sh0ABC;
        tick();
        tick();
        n_tests++;
        if ({tap_valid, busy, overrun, tap_last} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid/busy/ovr/last=%b required 0000",
                     {tap_valid, busy, overrun, tap_last});
        end
        n_tests++;
        if (tap_data !== 16'sh0000 || tap_index !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_data: data=%h index=%0d required 0000/0", tap_data, tap_index);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%0b required 1", in_ready);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_single_sample();
        apply_reset();
        send(16'sh1234);
        n_tests++;
        if (tap_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_cycle: valid=%0b busy=%0b required 0/1", tap_valid, busy);
        end
        read_frame(1'b0);
        n_tests++;
        if (got_n !== TAPS || got_cyc !== TAPS + 1) begin
            n_fail++;
            $display("FAIL t1_beats: beats=%0d cycles=%0d required %0d/%0d",
                     got_n, got_cyc, TAPS, TAPS + 1);
        end
        for (int i = 0; i < TAPS; i++) begin
            n_tests++;
            if (got_data[i] !== ((i == 0) ? 16'sh1234 : 16'sh0000) ||
                got_idx[i] !== ADDR_W'(i) || got_last[i] !== (i == TAPS - 1)) begin
                n_fail++;
                $display("FAIL t1_beat%0d: data=%h idx=%0d last=%0b", i,
                         got_data[i], got_idx[i], got_last[i]);
            end
        end
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || tap_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_done: ready=%0b busy=%0b valid=%0b required 1/0/0",
                     in_ready, busy, tap_valid);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int s = 1; s <= 40; s++) begin
            send(16'(s));
            read_frame(1'b0);
        end
        n_tests++;
        if (got_n !== TAPS) begin
            n_fail++;
            $display("FAIL t2_beats: beats=%0d required %0d", got_n, TAPS);
        end
        for (int i = 0; i < TAPS; i++) begin
            n_tests++;
            if (got_data[i] !== 16'(40 - i) || got_idx[i] !== ADDR_W'(i)) begin
                n_fail++;
                $display("FAIL t2_beat%0d: data=%0d idx=%0d required %0d/%0d", i,
                         got_data[i], got_idx[i], 40 - i, i);
            end
        end
    endtask

    task automatic test_back_pressure();
        apply_reset();
        send(16'sh0101);
        read_frame(1'b0);
        send(-16'sh0202);
        read_frame(1'b0);
        send(16'sh0303);
        read_frame(1'b1);
        n_tests++;
        if (got_n !== TAPS || stall_bad !== 0) begin
            n_fail++;
            $display("FAIL t3_stall: beats=%0d unstable=%0d required %0d/0",
                     got_n, stall_bad, TAPS);
        end
        for (int i = 0; i < TAPS; i++) begin
            n_tests++;
            if (got_data[i] !== exp_tap(i) || got_idx[i] !== ADDR_W'(i) ||
                got_last[i] !== (i == TAPS - 1)) begin
                n_fail++;
                $display("FAIL t3_beat%0d: data=%h idx=%0d required %h/%0d", i,
                         got_data[i], got_idx[i], exp_tap(i), i);
            end
        end
    endtask

    task automatic test_overrun();
        int seen;
        apply_reset();
        send(16'sh00AA);
        in_valid  = 1'b1;
        in_sample = 16'sh7777;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_set: overrun=%0b required 1", overrun);
        end
        read_frame(1'b0);
        send(16'sh00BB);
        read_frame(1'b0);
        n_tests++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_sticky: overrun=%0b required 1", overrun);
        end
        n_tests++;
        if (got_data[0] !== 16'sh00BB || got_data[1] !== 16'sh00AA || got_data[2] !== 16'sh0000) begin
            n_fail++;
            $display("FAIL t4_hist: taps=%h %h %h required 00bb 00aa 0000",
                     got_data[0], got_data[1], got_data[2]);
        end
        seen = 0;
        for (int i = 0; i < TAPS; i++) if (got_data[i] === 16'sh7777) seen++;
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL t4_dropped: 7777 seen %0d times required 0", seen);
        end
    endtask

    task automatic test_midframe_reset();
        int w;
        apply_reset();
        send(16'sh1111);
        read_frame(1'b0);
        send(16'sh2222);
        tap_ready = 1'b1;
        w = 0;
        while (!(tap_valid && tap_index == 5'd10) && w < 100) begin
            tick();
            w++;
        end
        n_tests++;
        if (tap_index !== 5'd10 || tap_data !== 16'sh0000) begin
            n_fail++;
            $display("FAIL t5_reach: idx=%0d data=%h required 10/0000", tap_index, tap_data);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (tap_valid !== 1'b0 || busy !== 1'b0 || tap_index !== 5'd0) begin
            n_fail++;
            $display("FAIL t5_abort: valid=%0b busy=%0b idx=%0d required 0/0/0",
                     tap_valid, busy, tap_index);
        end
        rst = 1'b1;
        tap_ready = 1'b0;
        hist.delete();
        send(16'sh0005);
        read_frame(1'b0);
        for (int i = 0; i < TAPS; i++) begin
            n_tests++;
            if (got_data[i] !== ((i == 0) ? 16'sh0005 : 16'sh0000)) begin
                n_fail++;
                $display("FAIL t5_beat%0d: data=%h required %h", i, got_data[i],
                         (i == 0) ? 16'h0005 : 16'h0000);
            end
        end
    endtask

    task automatic test_sign();
        apply_reset();
        send(16'sh8000);
        read_frame(1'b0);
        send(16'sh7FFF);
        read_frame(1'b0);
        n_tests++;
        if (got_data[0] !== 16'sh7FFF || got_data[1] !== 16'sh8000 || got_data[2] !== 16'sh0000) begin
            n_fail++;
            $display("FAIL t6_sign: taps=%h %h %h required 7fff 8000 0000",
                     got_data[0], got_data[1], got_data[2]);
        end
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_wrap();
        test_back_pressure();
        test_overrun();
        test_midframe_reset();
        test_sign();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
